// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in / serial-out shifter with valid/last framing and done pulse
// Optional even-parity trailer bit is built when PISO_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic             accept;
   logic             first_bit;
   logic [WIDTH-1:0] load_rest;
   logic             shift_bit;
   logic [WIDTH-1:0] shift_rest;
`ifdef PISO_PARITY_EN
   logic             parity;
`endif

   // shreg always holds the not-yet-sent bits aligned so the next one sits at the output end
   always_comb begin
      load_ready = (state == IDLE) || ((state == SHIFT) && sout_last);
      accept     = load_valid && load_ready;
      cnt_inc    = cnt + CW'(1);
      if (MSB_FIRST) begin
         first_bit  = din[WIDTH-1];
         load_rest  = {din[WIDTH-2:0], 1'b0};
         shift_bit  = shreg[WIDTH-1];
         shift_rest = {shreg[WIDTH-2:0], 1'b0};
      end else begin
         first_bit  = din[0];
         load_rest  = {1'b0, din[WIDTH-1:1]};
         shift_bit  = shreg[0];
         shift_rest = {1'b0, shreg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (sout_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg      <= '0;
         cnt        <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
         done       <= 1'b0;
`ifdef PISO_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            shreg      <= load_rest;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            cnt        <= '0;
`ifdef PISO_PARITY_EN
            parity     <= ^din;
`endif
         end else if (state == SHIFT) begin
            if (sout_last) begin
               // frame ended with no follow-on word; counter is left parked, not wrapped
               sout_valid <= 1'b0;
               sout       <= 1'b0;
               sout_last  <= 1'b0;
               done       <= 1'b1;
            end else begin
               cnt       <= cnt_inc;
               shreg     <= shift_rest;
               sout_last <= (cnt_inc == CW'(FRAME_LEN - 1));
`ifdef PISO_PARITY_EN
               if (cnt_inc == CW'(WIDTH)) sout <= parity;
               else                       sout <= shift_bit;
`else
               sout      <= shift_bit;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   typedef struct packed {
      logic b;
      logic last;
      logic done_after;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       lv0, lv1, ready0, ready1;
   logic [7:0] din0, din1;
   logic       s0, v0, l0, d0, s1, v1, l1, d1;

   ent_t q0[$];
   ent_t q1[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   pend[2];
   bit   more[2];
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(ready0), .din(din0),
      .sout(s0), .sout_valid(v0), .sout_last(l0), .done(d0));

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(ready1), .din(din1),
      .sout(s1), .sout_valid(v1), .sout_last(l1), .done(d1));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(int ch, logic [7:0] w, bit msb, bit done_after);
      ent_t e;
      for (int i = 0; i < FL; i++) begin
         if (i < 8) e.b = msb ? w[7-i] : w[i];
         else       e.b = ^w;
         e.last       = (i == FL - 1);
         e.done_after = (i == FL - 1) && done_after;
         if (ch == 0) q0.push_back(e);
         else         q1.push_back(e);
      end
   endtask

   task automatic mon(int ch, logic v, logic s, logic l, logic d, logic r);
      ent_t e;
      bit   empty;
      chk($sformatf("ch%0d done", ch), d, pend[ch]);
      pend[ch] = 1'b0;
      if (v) begin
         empty = (ch == 0) ? (q0.size() == 0) : (q1.size() == 0);
         if (empty) begin
            n_chk++;
            n_fail++;
            $display("FAIL ch%0d unexpected bit: got sout=%0b with empty scoreboard at %0t", ch, s, $time);
            more[ch] = 1'b0;
         end else begin
            if (ch == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("ch%0d sout", ch), s, e.b);
            chk($sformatf("ch%0d sout_last", ch), l, e.last);
            pend[ch] = e.done_after;
            more[ch] = !e.last;
         end
      end else begin
         chk($sformatf("ch%0d sout_valid gap", ch), v, more[ch]);
         chk($sformatf("ch%0d idle sout", ch), s, 1'b0);
         chk($sformatf("ch%0d idle sout_last", ch), l, 1'b0);
         more[ch] = 1'b0;
      end
      if (r) begin
         if (ch == 0) q0.delete();
         else         q1.delete();
         pend[ch] = 1'b0;
         more[ch] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, v0, s0, l0, d0, reset);
         mon(1, v1, s1, l1, d1, reset);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(int ch, logic [7:0] w, bit done_after);
      int t = 0;
      push_frame(ch, w, ch == 0, done_after);
      if (ch == 0) begin lv0 = 1'b1; din0 = w; end
      else         begin lv1 = 1'b1; din1 = w; end
      while ((((ch == 0) ? ready0 : ready1) !== 1'b1) && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL ch%0d load_ready timeout: got 0 expected 1", ch);
      end
      step();
      if (ch == 0) lv0 = 1'b0;
      else         lv1 = 1'b0;
   endtask

   task automatic wait_idle(int ch);
      int t = 0;
      while ((((ch == 0) ? q0.size() : q1.size()) != 0 || more[ch] || pend[ch]) && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL ch%0d drain timeout: got pending bits expected empty", ch);
      end
      repeat (2) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      lv0 = 1'b0; lv1 = 1'b0; din0 = '0; din1 = '0;
      repeat (3) step();
      reset = 1'b0;
      chk("reset sout_valid", v0, 1'b0);
      chk("reset sout", s0, 1'b0);
      chk("reset sout_last", l0, 1'b0);
      chk("reset done", d0, 1'b0);
      chk("reset load_ready msb", ready0, 1'b1);
      chk("reset load_ready lsb", ready1, 1'b1);
      mon_en = 1'b1;

      // single MSB-first frame, busy window
      load_word(0, 8'hC9, 1'b1);
      for (int i = 1; i < FL; i++) begin
         chk($sformatf("busy load_ready bit%0d", i), ready0, 1'b0);
         step();
      end
      chk("last bit load_ready", ready0, 1'b1);
      wait_idle(0);

      // LSB-first frame
      load_word(1, 8'hC9, 1'b1);
      wait_idle(1);

      // back-to-back
      load_word(0, 8'hC9, 1'b0);
      load_word(0, 8'h3A, 1'b1);
      wait_idle(0);

      // load attempts while busy are ignored
      load_word(0, 8'hC9, 1'b1);
      step();
      lv0 = 1'b1;
      din0 = 8'hFF;
      for (int i = 2; i <= 6; i++) begin
         chk($sformatf("ignore load_ready bit%0d", i), ready0, 1'b0);
         step();
      end
      lv0 = 1'b0;
      wait_idle(0);

      // reset during bit 4
      load_word(0, 8'hC9, 1'b1);
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset sout_valid", v0, 1'b0);
      chk("midreset sout", s0, 1'b0);
      chk("midreset done", d0, 1'b0);
      chk("midreset load_ready", ready0, 1'b1);
      load_word(0, 8'h55, 1'b1);
      wait_idle(0);

`ifdef PISO_PARITY_EN
      load_word(0, 8'h07, 1'b1);
      wait_idle(0);
`endif

      chk("final scoreboard msb empty", q0.size(), 0);
      chk("final scoreboard lsb empty", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
